instruction_fetch_unit: RTL and testbench

//  Owns the program counter and fetches one instruction word per transaction from instruction memory.

---
 rtl/instruction_fetch_unit_pkg.sv | 14 +
 rtl/instruction_fetch_unit_skid.sv | 37 +++
 rtl/instruction_fetch_unit.sv | 153 +++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: reset PC default,
// PC increment and fetch FSM state encodings.
package instruction_fetch_unit_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int unsigned PC_INCR          = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_unit_skid.sv
// fetch_skid_buffer: one-entry {instr, pc} holding register with valid flag.
// Flush wins over push; a push in the same cycle as a pop refills the entry.
module fetch_skid_buffer
    import instruction_fetch_unit_pkg::*;
#(
    parameter int unsigned BUS_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  push,
    input  logic                  pop,
    input  logic [BUS_WIDTH-1:0]  push_instr,
    input  logic [ADDR_WIDTH-1:0] push_pc,
    output logic                  valid,
    output logic [BUS_WIDTH-1:0]  instr,
    output logic [ADDR_WIDTH-1:0] pc
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (push) begin
            valid <= 1'b1;
            instr <= push_instr;
            pc    <= push_pc;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: PC, fetch FSM, output register and skid buffer.
// Optional FETCH_PERF_CNT_EN adds fetch/stall performance counters.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int unsigned            BUS_WIDTH  = 32,
    parameter int unsigned            ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_rvalid,
    input  logic [BUS_WIDTH-1:0]  imem_rdata,
    input  logic                  stall_in,
    input  logic                  redirect_en,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]           perf_fetch_cnt,
    output logic [31:0]           perf_stall_cnt,
`endif
    output logic                  instr_valid,
    output logic [BUS_WIDTH-1:0]  instr_out,
    output logic [ADDR_WIDTH-1:0] pc_out
);

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

    fetch_state_e          state;
    fetch_state_e          state_next;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] flush_addr;

    logic                  resp;
    logic                  consume;
    logic                  fetch_resp;
    logic                  take_out;
    logic                  skid_push;
    logic                  skid_pop;

    logic                  skid_valid;
    logic [BUS_WIDTH-1:0]  skid_instr;
    logic [ADDR_WIDTH-1:0] skid_pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        imem_req   = ((state == ST_FETCH) && !skid_valid) || (state == ST_FLUSH);
        imem_addr  = (state == ST_FLUSH) ? flush_addr : pc;

        if (redirect_en) begin
            // An unanswered request must be seen through before fetching the new target.
            state_next = (imem_req && !imem_rvalid) ? ST_FLUSH : ST_FETCH;
        end else begin
            case (state)
                ST_IDLE:  state_next = ST_FETCH;
                ST_FETCH: state_next = ST_FETCH;
                ST_FLUSH: state_next = imem_rvalid ? ST_FETCH : ST_FLUSH;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        resp       = imem_req && imem_rvalid;
        consume    = instr_valid && !stall_in;
        fetch_resp = (state == ST_FETCH) && resp && !redirect_en;
        take_out   = !skid_valid && (!instr_valid || consume);
        skid_push  = fetch_resp && !take_out;
        skid_pop   = !redirect_en && skid_valid && consume;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= RESET_PC & ALIGN_MASK;
        end else if (redirect_en) begin
            pc <= redirect_pc & ALIGN_MASK;
        end else if (fetch_resp) begin
            pc <= pc + ADDR_WIDTH'(PC_INCR);
        end
    end

    // Keeps the address of the abandoned request stable while flushing, even
    // if further redirects move pc.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flush_addr <= RESET_PC & ALIGN_MASK;
        end else if (state != ST_FLUSH) begin
            flush_addr <= pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr_valid <= 1'b0;
            instr_out   <= '0;
            pc_out      <= '0;
        end else if (redirect_en) begin
            instr_valid <= 1'b0;
        end else if (skid_valid && consume) begin
            instr_valid <= 1'b1;
            instr_out   <= skid_instr;
            pc_out      <= skid_pc;
        end else if (fetch_resp && take_out) begin
            instr_valid <= 1'b1;
            instr_out   <= imem_rdata;
            pc_out      <= pc;
        end else if (consume) begin
            instr_valid <= 1'b0;
        end
    end

    fetch_skid_buffer #(
        .BUS_WIDTH  (BUS_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect_en),
        .push       (skid_push),
        .pop        (skid_pop),
        .push_instr (imem_rdata),
        .push_pc    (pc),
        .valid      (skid_valid),
        .instr      (skid_instr),
        .pc         (skid_pc)
    );

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (consume) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (instr_valid && stall_in) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: imem model returning the
// address as data, scoreboard of expected {instr, pc}, directed scenarios.
module tb_instruction_fetch_unit;

    localparam int unsigned BW = 32;
    localparam int unsigned AW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_rvalid;
    logic [BW-1:0] imem_rdata;
    logic          stall_in;
    logic          redirect_en;
    logic [AW-1:0] redirect_pc;
    logic          instr_valid;
    logic [BW-1:0] instr_out;
    logic [AW-1:0] pc_out;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]   perf_fetch_cnt;
    logic [31:0]   perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    instruction_fetch_unit #(
        .BUS_WIDTH  (BW),
        .ADDR_WIDTH (AW),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .stall_in    (stall_in),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt),
`endif
        .instr_valid (instr_valid),
        .instr_out   (instr_out),
        .pc_out      (pc_out)
    );

    // imem model: answers after `latency` wait cycles, data = address
    int unsigned latency = 0;
    int unsigned wait_cnt = 0;
    logic        force_rvalid = 1'b0;

    assign imem_rvalid = (imem_req && (wait_cnt >= latency)) || force_rvalid;
    assign imem_rdata  = imem_addr;

    always @(posedge clk) begin
        wait_cnt <= (imem_req && !imem_rvalid && rst_n) ? wait_cnt + 1 : 0;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic [BW-1:0] instr;
        logic [AW-1:0] pc;
    } item_t;

    item_t         sb[$];
    item_t         exp_item;
    logic [AW-1:0] exp_fetch = '0;
    logic          discard = 1'b0;
    logic          prev_pending = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic          prev_hold = 1'b0;
    logic [BW-1:0] prev_instr = '0;
    logic [AW-1:0] prev_pc = '0;
    int unsigned   resp_cnt = 0;

    // Monitor/scoreboard, sampled mid-cycle
    always @(negedge clk) begin
        if (prev_pending) begin
            check("req_held", {63'd0, imem_req}, 64'd1);
            check("addr_held", {32'd0, imem_addr}, {32'd0, prev_addr});
        end
        if (prev_hold) begin
            check("hold_valid", {63'd0, instr_valid}, 64'd1);
            check("hold_pc", {32'd0, pc_out}, {32'd0, prev_pc});
            check("hold_instr", {32'd0, instr_out}, {32'd0, prev_instr});
        end
        prev_pending = imem_req && !imem_rvalid && rst_n;
        prev_addr    = imem_addr;
        prev_hold    = instr_valid && stall_in && rst_n && !redirect_en;
        prev_pc      = pc_out;
        prev_instr   = instr_out;

        if (!rst_n) begin
            sb.delete();
            exp_fetch = '0;
            discard   = 1'b0;
        end else begin
            if (instr_valid && !stall_in) begin
                checks++;
                assert (sb.size() != 0) else begin
                    errors++;
                    $error("FAIL sb_empty: observed pc_out=%0h expected=no word pending", pc_out);
                end
                if (sb.size() != 0) begin
                    exp_item = sb.pop_front();
                    check("sb_pc", {32'd0, pc_out}, {32'd0, exp_item.pc});
                    check("sb_instr", {32'd0, instr_out}, {32'd0, exp_item.instr});
                end
            end
            if (redirect_en) begin
                sb.delete();
                exp_fetch = redirect_pc & ~32'd3;
                discard   = imem_req && !imem_rvalid;
            end else if (imem_req && imem_rvalid) begin
                resp_cnt++;
                if (discard) begin
                    discard = 1'b0;
                end else begin
                    check("fetch_addr", {32'd0, imem_addr}, {32'd0, exp_fetch});
                    sb.push_back('{instr: exp_fetch, pc: exp_fetch});
                    exp_fetch = exp_fetch + 32'd4;
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    int unsigned r0;
    logic        found;

    initial begin
        rst_n       = 1'b0;
        stall_in    = 1'b0;
        redirect_en = 1'b0;
        redirect_pc = '0;

        // 1: reset and zero-wait streaming
        repeat (3) tick();
        check("rst_valid", {63'd0, instr_valid}, 64'd0);
        check("rst_req", {63'd0, imem_req}, 64'd0);
        check("rst_pc_out", {32'd0, pc_out}, 64'd0);
        check("rst_instr_out", {32'd0, instr_out}, 64'd0);
        rst_n = 1'b1;
        #1;
        check("idle_req", {63'd0, imem_req}, 64'd0);
        tick();
        check("first_req", {63'd0, imem_req}, 64'd1);
        check("first_addr", {32'd0, imem_addr}, 64'h0);
        check("first_valid_lat", {63'd0, instr_valid}, 64'd0);
        tick();
        check("t1_valid", {63'd0, instr_valid}, 64'd1);
        check("t1_pc", {32'd0, pc_out}, 64'h0);
        check("t1_addr", {32'd0, imem_addr}, 64'h4);
        tick();
        check("t1_pc4", {32'd0, pc_out}, 64'h4);
        tick();
        check("t1_pc8", {32'd0, pc_out}, 64'h8);
        check("t1_instr8", {32'd0, instr_out}, 64'h8);

        // 2: three wait cycles per request -> one word every four cycles
        latency = 3;
        repeat (8) tick();
        r0 = resp_cnt;
        repeat (16) tick();
        check("wait3_rate", 64'(resp_cnt - r0), 64'd4);

        // 3: stall with word 8 on output, next word parked in skid
        latency     = 0;
        redirect_en = 1'b1;
        redirect_pc = 32'h8;
        stall_in    = 1'b1;
        tick();
        redirect_en = 1'b0;
        tick();
        check("st_valid", {63'd0, instr_valid}, 64'd1);
        check("st_pc8", {32'd0, pc_out}, 64'h8);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("st_req_low", {63'd0, imem_req}, 64'd0);
            check("st_hold_pc", {32'd0, pc_out}, 64'h8);
        end
        tick();
        stall_in = 1'b0;
        tick();
        check("st_rel_pc12", {32'd0, pc_out}, 64'hC);
        tick();
        check("st_rel_pc16", {32'd0, pc_out}, 64'h10);

        // 4: redirect while request to 0x10 outstanding
        latency     = 2;
        redirect_en = 1'b1;
        redirect_pc = 32'h10;
        tick();
        redirect_en = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (imem_req && imem_addr == 32'h10 && wait_cnt == 0) found = 1'b1;
            else tick();
        end
        check("wait_req_0x10", {63'd0, found}, 64'd1);
        redirect_en = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect_en = 1'b0;
        check("fl_req", {63'd0, imem_req}, 64'd1);
        check("fl_addr", {32'd0, imem_addr}, 64'h10);
        tick();
        check("fl_addr_rv", {32'd0, imem_addr}, 64'h10);
        tick();
        check("fl_new_req", {63'd0, imem_req}, 64'd1);
        check("fl_new_addr", {32'd0, imem_addr}, 64'h100);
        check("fl_no_valid", {63'd0, instr_valid}, 64'd0);
        latency     = 0;
        redirect_en = 1'b1;
        redirect_pc = 32'h103;
        tick();
        redirect_en = 1'b0;
        check("unal_addr", {32'd0, imem_addr}, 64'h100);
        check("unal_valid0", {63'd0, instr_valid}, 64'd0);
        tick();
        check("unal_pc_out", {32'd0, pc_out}, 64'h100);

        // 5: redirect with rvalid, stall and full skid
        stall_in = 1'b1;
        repeat (3) tick();
        check("sk_req_low", {63'd0, imem_req}, 64'd0);
        check("sk_valid", {63'd0, instr_valid}, 64'd1);
        force_rvalid = 1'b1;
        redirect_en  = 1'b1;
        redirect_pc  = 32'h200;
        tick();
        force_rvalid = 1'b0;
        redirect_en  = 1'b0;
        check("sk_valid0", {63'd0, instr_valid}, 64'd0);
        check("sk_req", {63'd0, imem_req}, 64'd1);
        check("sk_addr", {32'd0, imem_addr}, 64'h200);
        tick();
        check("sk_pc_out", {32'd0, pc_out}, 64'h200);
        check("sk_next_addr", {32'd0, imem_addr}, 64'h204);
        stall_in = 1'b0;
        repeat (5) tick();

        // 6: counters over 10 words / 3 stalls, then reset mid-run
`ifdef FETCH_PERF_CNT_EN
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 13; i++) begin
            stall_in = (i == 3 || i == 4 || i == 8);
            tick();
        end
        check("perf_fetch", {32'd0, perf_fetch_cnt}, 64'd10);
        check("perf_stall", {32'd0, perf_stall_cnt}, 64'd3);
`endif
        rst_n = 1'b0;
        tick();
        check("mr_valid", {63'd0, instr_valid}, 64'd0);
        check("mr_req", {63'd0, imem_req}, 64'd0);
`ifdef FETCH_PERF_CNT_EN
        check("mr_perf_fetch", {32'd0, perf_fetch_cnt}, 64'd0);
        check("mr_perf_stall", {32'd0, perf_stall_cnt}, 64'd0);
`endif
        rst_n = 1'b1;
        tick();
        check("mr_req1", {63'd0, imem_req}, 64'd1);
        check("mr_addr", {32'd0, imem_addr}, 64'h0);
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
